// File: rtl/uart_tx_stream_if.sv
// AXI-Stream byte channel feeding the UART transmitter.
interface uart_tx_stream_if #(
  parameter int unsigned WORD_LEN = 8
) ();
  logic [WORD_LEN-1:0] s_tdata;
  logic                s_tvalid;
  logic                s_tlast;
  logic                s_tready;

  modport master (output s_tdata, output s_tvalid, output s_tlast, input s_tready);
  modport slave  (input s_tdata, input s_tvalid, input s_tlast, output s_tready);
endinterface

// File: rtl/uart_tx_stream.sv
// UART transmitter fed from an AXI-Stream FIFO; run-time parity/stop selection,
// gapless back-to-back frames and packet-end pulse.
module uart_tx_stream #(
  parameter int unsigned CLK_RATE   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned WORD_LEN   = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_stream_if.slave   s_axis,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  output logic              uart_tx,
  output logic              tx_busy,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              frame_done,
  output logic              pkt_done
);

  localparam int unsigned BAUD_DIV = CLK_RATE / BAUD;
  localparam int unsigned BAUD_W   = $clog2(BAUD_DIV);
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned BIT_W    = $clog2(WORD_LEN);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [BIT_W-1:0]    bit_idx;
  logic [WORD_LEN-1:0] shift_reg;
  logic                par_bit;
  logic                par_en;
  logic                stop2;
  logic                stop_idx;
  logic                last_flag;

  logic [WORD_LEN:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [WORD_LEN:0]   rd_word;
  logic [WORD_LEN-1:0] rd_data;
  logic                wr_en;
  logic                pop;
  logic                fifo_nempty;
  logic                bit_end;
  logic                frame_end;
  logic                par_calc;

  assign s_axis.s_tready = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign wr_en       = s_axis.s_tvalid & s_axis.s_tready;
  assign fifo_nempty = (fifo_count != '0);
  assign bit_end     = (baud_cnt == BAUD_W'(BAUD_DIV - 1));
  assign frame_end   = (state == STOP) && bit_end && (!stop2 || stop_idx);
  // Load from IDLE, or straight out of the last stop bit for gapless framing.
  assign pop         = fifo_nempty && ((state == IDLE) || frame_end);
  assign rd_word     = mem[rd_ptr];
  assign rd_data     = rd_word[WORD_LEN-1:0];

  always_comb begin
    par_calc = 1'b1;
    case (cfg_parity)
      2'b01:   par_calc = ^rd_data;
      2'b10:   par_calc = ~^rd_data;
      default: par_calc = 1'b1;
    endcase
  end

  // Storage carries tlast in the top bit; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {s_axis.s_tlast, s_axis.s_tdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Frame sequencer; config is latched at load so mid-frame changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      par_en     <= 1'b0;
      stop2      <= 1'b0;
      stop_idx   <= 1'b0;
      last_flag  <= 1'b0;
      uart_tx    <= 1'b1;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
      pkt_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      pkt_done   <= 1'b0;
      if (state != IDLE) baud_cnt <= bit_end ? '0 : baud_cnt + BAUD_W'(1);

      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          tx_busy <= 1'b0;
        end
        START: if (bit_end) begin
          state     <= DATA;
          bit_idx   <= '0;
          uart_tx   <= shift_reg[0];
          shift_reg <= shift_reg >> 1;
        end
        DATA: if (bit_end) begin
          if (bit_idx == BIT_W'(WORD_LEN - 1)) begin
            stop_idx <= 1'b0;
            if (par_en) begin
              state   <= PARITY;
              uart_tx <= par_bit;
            end else begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end
          end else begin
            bit_idx   <= bit_idx + BIT_W'(1);
            uart_tx   <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
        end
        PARITY: if (bit_end) begin
          state    <= STOP;
          stop_idx <= 1'b0;
          uart_tx  <= 1'b1;
        end
        STOP: if (bit_end) begin
          if (stop2 && !stop_idx) begin
            stop_idx <= 1'b1;
          end else begin
            frame_done <= 1'b1;
            pkt_done   <= last_flag;
            state      <= IDLE;
            tx_busy    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // A load overrides whatever the case chose (IDLE or end of frame).
      if (pop) begin
        state     <= START;
        uart_tx   <= 1'b0;
        tx_busy   <= 1'b1;
        shift_reg <= rd_data;
        last_flag <= rd_word[WORD_LEN];
        par_en    <= (cfg_parity != 2'b00);
        par_bit   <= par_calc;
        stop2     <= cfg_stop2;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream: frame shapes, parity/stop modes, burst, packets, reset.
module tb_uart_tx_stream;

  localparam int unsigned W = 8;
  typedef logic [2047:0] vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;
  logic       uart_tx;
  logic       tx_busy;
  logic [4:0] fifo_count;
  logic       frame_done;
  logic       pkt_done;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t wave, fdm, pdm, rdy;
  logic busy0;
  bit   ok;
  int   lat;

  uart_tx_stream_if #(.WORD_LEN(W)) s_axis ();

  uart_tx_stream #(
    .CLK_RATE(1_000_000), .BAUD(100_000), .WORD_LEN(W), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .s_axis(s_axis),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .uart_tx(uart_tx), .tx_busy(tx_busy), .fifo_count(fifo_count),
    .frame_done(frame_done), .pkt_done(pkt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each character of s is one bit held for 10 cycles.
  function automatic vec_t wave_of(string s);
    vec_t w = '0;
    for (int i = 0; i < s.len(); i++)
      for (int c = 0; c < 10; c++) w[i*10+c] = (s[i] == 8'h31);
    return w;
  endfunction

  // 8N1 frame string: start, data LSB first, stop.
  function automatic string frame_str(logic [7:0] d);
    string s = "0";
    for (int i = 0; i < 8; i++) s = d[i] ? {s, "1"} : {s, "0"};
    return {s, "1"};
  endfunction

  function automatic vec_t pulses_at(int period, int count);
    vec_t v = '0;
    for (int k = 1; k <= count; k++) v[period*k] = 1'b1;
    return v;
  endfunction

  function automatic int first_diff(vec_t a, vec_t b, int n);
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  // Caller sits on a negedge; word is accepted at the next posedge.
  task automatic push(input logic [7:0] d, input logic last);
    int n = 0;
    while (s_axis.s_tready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: s_tready=%b want 1", s_axis.s_tready);
    end
    s_axis.s_tdata  = d;
    s_axis.s_tlast  = last;
    s_axis.s_tvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Wait for the start bit, then record index 0..ncyc at successive negedges.
  task automatic capture(input int ncyc, output bit found, output int waited,
                         output vec_t w, output vec_t f, output vec_t p,
                         output vec_t r, output logic b0);
    found = 0; waited = 0; w = '0; f = '0; p = '0; r = '0; b0 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      waited = i + 1;
      if (uart_tx === 1'b0) begin
        found = 1;
        break;
      end
    end
    if (!found) return;
    for (int c = 0; c <= ncyc; c++) begin
      if (c > 0) @(negedge clk);
      w[c] = uart_tx; f[c] = frame_done; p[c] = pkt_done; r[c] = s_axis.s_tready;
      if (c == 0) b0 = tx_busy;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    s_axis.s_tdata = '0; s_axis.s_tvalid = 1'b0; s_axis.s_tlast = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (uart_tx !== 1'b1)       begin n_bad++; $display("FAIL rst_uart_tx: got %b want 1", uart_tx); end
    n_cmp++; if (s_axis.s_tready !== 1'b1) begin n_bad++; $display("FAIL rst_tready: got %b want 1", s_axis.s_tready); end
    n_cmp++; if (tx_busy !== 1'b0)       begin n_bad++; $display("FAIL rst_busy: got %b want 0", tx_busy); end
    n_cmp++; if (fifo_count !== 5'd0)    begin n_bad++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    n_cmp++; if (frame_done !== 1'b0)    begin n_bad++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
    n_cmp++; if (pkt_done !== 1'b0)      begin n_bad++; $display("FAIL rst_pkt_done: got %b want 0", pkt_done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    vec_t exp_w;
    int d;
    cfg_parity = 2'b01; cfg_stop2 = 1'b0;
    push(8'hA5, 1'b0);
    s_axis.s_tvalid = 1'b0;
    n_cmp++; if (fifo_count !== 5'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", fifo_count); end
    n_cmp++; if (uart_tx !== 1'b1)    begin n_bad++; $display("FAIL single_pre_idle: got %b want 1", uart_tx); end
    capture(110, ok, lat, wave, fdm, pdm, rdy, busy0);
    n_cmp++; if (lat !== 1)      begin n_bad++; $display("FAIL single_latency: got %0d want 1", lat); end
    n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy0); end
    exp_w = wave_of("01010010101");
    d = first_diff(wave, exp_w, 110);
    n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL single_wave: cycle %0d got %b want %b", d, wave[d], exp_w[d]); end
    d = first_diff(fdm, pulses_at(110, 1), 111);
    n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL single_frame_done: cycle %0d got %b", d, fdm[d]); end
    n_cmp++; if (wave[110] !== 1'b1) begin n_bad++; $display("FAIL single_post_idle: got %b want 1", wave[110]); end
    n_cmp++; if (tx_busy !== 1'b0)   begin n_bad++; $display("FAIL single_busy_fall: got %b want 0", tx_busy); end
  endtask

  task automatic test_parity_modes();
    logic [1:0] modes [3] = '{2'b10, 2'b11, 2'b00};
    string      exps  [3] = '{"01010010111", "01010010111", "0101001011"};
    vec_t exp_w;
    int d, n;
    for (int m = 0; m < 3; m++) begin
      cfg_parity = modes[m]; cfg_stop2 = 1'b0;
      push(8'hA5, 1'b0);
      s_axis.s_tvalid = 1'b0;
      n = exps[m].len() * 10;
      capture(n, ok, lat, wave, fdm, pdm, rdy, busy0);
      exp_w = wave_of(exps[m]);
      d = first_diff(wave, exp_w, n);
      n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL parity%0d_wave: cycle %0d got %b want %b", m, d, wave[d], exp_w[d]); end
      d = first_diff(fdm, pulses_at(n, 1), n + 1);
      n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL parity%0d_len: frame_done cycle %0d got %b", m, d, fdm[d]); end
    end
  endtask

  task automatic test_stop2();
    vec_t exp_w;
    int d;
    cfg_parity = 2'b00; cfg_stop2 = 1'b1;
    push(8'h00, 1'b0);
    s_axis.s_tvalid = 1'b0;
    fork
      capture(110, ok, lat, wave, fdm, pdm, rdy, busy0);
      begin repeat (40) @(negedge clk); cfg_stop2 = 1'b0; end
    join
    exp_w = wave_of("00000000011");
    d = first_diff(wave, exp_w, 110);
    n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL stop2_wave: cycle %0d got %b want %b", d, wave[d], exp_w[d]); end
    d = first_diff(fdm, pulses_at(110, 1), 111);
    n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL stop2_len: frame_done cycle %0d got %b", d, fdm[d]); end
  endtask

  task automatic test_packet();
    vec_t exp_w, exp_p;
    int d;
    cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    fork
      begin
        push(8'h10, 1'b0); push(8'h20, 1'b0); push(8'h30, 1'b1);
        s_axis.s_tvalid = 1'b0; s_axis.s_tlast = 1'b0;
      end
      capture(300, ok, lat, wave, fdm, pdm, rdy, busy0);
    join
    exp_w = wave_of({"0000010001", "0000001001", "0000011001"});
    d = first_diff(wave, exp_w, 300);
    n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL pkt_wave: cycle %0d got %b want %b", d, wave[d], exp_w[d]); end
    d = first_diff(fdm, pulses_at(100, 3), 301);
    n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL pkt_frame_done: cycle %0d got %b", d, fdm[d]); end
    exp_p = '0; exp_p[300] = 1'b1;
    d = first_diff(pdm, exp_p, 301);
    n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL pkt_done: cycle %0d got %b want %b", d, pdm[d], exp_p[d]); end
  endtask

  task automatic test_back_to_back();
    vec_t exp_w;
    string s;
    int d;
    cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    s = "";
    for (int v = 1; v <= 17; v++) s = {s, frame_str(8'(v))};
    exp_w = wave_of(s);
    fork
      begin
        for (int v = 1; v <= 17; v++) push(8'(v), 1'b0);
        s_axis.s_tvalid = 1'b0;
      end
      capture(1700, ok, lat, wave, fdm, pdm, rdy, busy0);
    join
    d = first_diff(wave, exp_w, 1700);
    n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL burst_wave: cycle %0d got %b want %b", d, wave[d], exp_w[d]); end
    d = first_diff(fdm, pulses_at(100, 17), 1701);
    n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL burst_frame_done: cycle %0d got %b", d, fdm[d]); end
    n_cmp++; if (rdy[14] !== 1'b1)  begin n_bad++; $display("FAIL burst_ready_pre: got %b want 1", rdy[14]); end
    n_cmp++; if (rdy[15] !== 1'b0)  begin n_bad++; $display("FAIL burst_ready_full: got %b want 0", rdy[15]); end
    n_cmp++; if (rdy[99] !== 1'b0)  begin n_bad++; $display("FAIL burst_ready_hold: got %b want 0", rdy[99]); end
    n_cmp++; if (rdy[100] !== 1'b1) begin n_bad++; $display("FAIL burst_ready_back: got %b want 1", rdy[100]); end
    n_cmp++; if (fifo_count !== 5'd0) begin n_bad++; $display("FAIL burst_drained: got %0d want 0", fifo_count); end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    fork
      begin
        push(8'h41, 1'b0); push(8'h42, 1'b0); push(8'h43, 1'b0);
        s_axis.s_tvalid = 1'b0;
      end
      capture(150, ok, lat, wave, fdm, pdm, rdy, busy0);
    join
    n_cmp++; if (wave[150] !== 1'b0)  begin n_bad++; $display("FAIL rmid_pre_bit: got %b want 0", wave[150]); end
    n_cmp++; if (fifo_count !== 5'd1) begin n_bad++; $display("FAIL rmid_pre_count: got %0d want 1", fifo_count); end
    rst = 1'b1;
    #1;
    n_cmp++; if (uart_tx !== 1'b1)         begin n_bad++; $display("FAIL rmid_uart_tx: got %b want 1", uart_tx); end
    n_cmp++; if (fifo_count !== 5'd0)      begin n_bad++; $display("FAIL rmid_count: got %0d want 0", fifo_count); end
    n_cmp++; if (s_axis.s_tready !== 1'b1) begin n_bad++; $display("FAIL rmid_tready: got %b want 1", s_axis.s_tready); end
    n_cmp++; if (tx_busy !== 1'b0)         begin n_bad++; $display("FAIL rmid_busy: got %b want 0", tx_busy); end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || frame_done !== 1'b0 || tx_busy !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL rmid_quiet: got %0d active cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity_modes();
    test_stop2();
    test_packet();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
